serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial two's-complement subtractor computing `diff = a - b - bin` over `WIDTH` clock cycles, one bit per cycle, LSB first. It is the inverse-direction companion to the team's combinational adder-with-carry. It pairs with that adder in datapaths where area matters more than latency. It has a start/ack handshake and holds its result until the consumer acknowledges it.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥2)
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  WIDTH  minuend; captured when start is accepted
- `b`  in  WIDTH  subtrahend; captured when start is accepted
- `bin`  in  1  borrow-in; captured when start is accepted
- `busy`  out  1  high in RUN and DONE
- `res_valid`  out  1  high in DONE; result outputs are stable while high
- `res_ack`  in  1  consumer accepts the result; sampled only in DONE
- `diff`  out  WIDTH  `(a - b - bin) mod 2^WIDTH`
- `bout`  out  1  unsigned borrow-out; 1 iff `a < b + bin`
- `ovf`  out  1  signed overflow: borrow into the MSB XOR the borrow out of the MSB
- `zero`  out  1  `diff == 0`

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - When `start=1`: load shift registers `sa<=a`, `sb<=b`, borrow `<=bin`, bit counter `<=0`; go to RUN.
- **RUN** (one bit-step per cycle)
  - `d = sa[0]^sb[0]^brw`
  - `brw_n = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw)`
  - Shift `sa` and `sb` right by 1.
  - Shift `d` into `diff` at the MSB; `diff` is a right-shift register.
  - Update `brw` and increment the counter.
  - On the step where counter = `WIDTH-1`: record `brw` (the borrow into the MSB) as `bmsb`; go to DONE.
- **DONE**
  - Outputs: `bout=brw`, `ovf=bmsb^brw`, `zero=(diff==0)`; all registered and held.
  - When `res_ack=1`: go to IDLE. Result outputs keep their values until the next accepted start, but `res_valid` drops.
- `start` is ignored in RUN and DONE; it is not queued.
- `start` and `res_ack` both high in DONE: the ack is taken and the start is dropped. The requester must re-assert start in IDLE.
- `res_ack` outside DONE: no effect.
- Counter width is `$clog2(WIDTH)`, and the counter never wraps inside RUN.

## Timing
- **Reset** (asynchronous, immediate):
  - State goes to IDLE.
  - `busy=0`, `res_valid=0`, `diff=0`, `bout=0`, `ovf=0`, `zero=0`.
  - Counter, shift registers and borrow cleared.
- **Reset mid-RUN or mid-DONE:** the operation is discarded with no partial result. The first start after `rst_n` rises is accepted normally.
- **Latency:**
  - Start sampled at edge E0.
  - Bit-steps at edges E1..E_WIDTH.
  - `res_valid` goes high after E_WIDTH, i.e. `WIDTH` cycles after acceptance.
- **busy:** rises after E0 and falls after the edge that samples `res_ack`.
- **Throughput:** one operation per `WIDTH+2` cycles minimum. That is start, `WIDTH` steps, then ack in the first DONE cycle; the next start is sampled in IDLE.
- Input operands may change freely after E0.

## Structure
- **Package `serial_sub_pkg`:**
  - state enum `sub_state_t` {IDLE, RUN, DONE}
  - default-width constant `SUB_WIDTH_DEF = 8`
- **Sub-module `sub_bit_cell`:** a combinational 1-bit full subtractor.
  - Ports `x`, `y`, `bi` → `d`, `bo`.
  - Instantiated once in `serial_sub`.
- Everything else (FSM, counter, shift registers, flags) lives in `serial_sub`.

## Test plan
- `a=8'h00`, `b=8'h01`, `bin=0` → after 8 cycles: `diff=8'hFF`, `bout=1`, `ovf=0`, `zero=0`.
- `a=8'h80`, `b=8'h01`, `bin=0` → `diff=8'h7F`, `bout=0`, `ovf=1`, `zero=0`.
- `a=8'h05`, `b=8'h05`, `bin=0` → `diff=8'h00`, `bout=0`, `ovf=0`, `zero=1`. Then `a=8'hFF`, `b=8'h00`, `bin=1` → `diff=8'hFE`, `bout=0`.
- Hold `res_ack=0` for 5 cycles in DONE while pulsing `start` with new operands → `res_valid` and the result stay unchanged and the start is ignored. Then ack with `start=1` in the same cycle → IDLE, no new operation begins.
- Assert `rst_n=0` at bit-step 4 of `a=8'h10`, `b=8'h20` → all outputs are 0 immediately. Then start `8'h10 - 8'h20` → `diff=8'hF0`, `bout=1`, `ovf=0`.
- Random sweep of 1000 operations at `WIDTH=8` and `WIDTH=16` against the reference model `{bout,diff} = a - b - bin`, with `ovf` checked against signed arithmetic. Check `res_valid` exactly `WIDTH` cycles after start each time.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and defaults for the bit-serial subtractor.
//   sub_state_t   : controller states (IDLE, RUN, DONE)
//   SUB_WIDTH_DEF : default operand/result width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result handshake bundle for serial_sub.
//   master : requester side (drives start, a, b, bin, res_ack)
//   slave  : subtractor side (drives busy, res_valid, diff, bout, ovf, zero)
interface serial_sub_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             res_valid;
    logic             res_ack;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, bin, res_ack,
        input  busy, res_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  start, a, b, bin, res_ack,
        output busy, res_valid, diff, bout, ovf, zero
    );

endinterface

// File: rtl/serial_sub_bit_cell.sv
// sub_bit_cell: combinational 1-bit full subtractor, d = x - y - bi.
//   x, y, bi : minuend bit, subtrahend bit, borrow-in
//   d, bo    : difference bit, borrow-out
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor, diff = a - b - bin,
// one bit per clock LSB first, with a start/ack result handshake.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_sub_if.slave (start/a/b/bin in, busy/res_valid/result out,
//           res_ack in)
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last result
// RUN   | one bit-step per cycle, WIDTH steps
// DONE  | result valid and held until res_ack
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub_if.slave bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state, state_n;
    logic [WIDTH-1:0] sa, sb, diff_r;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             bout_r, ovf_r, zero_r;
    logic             load, step, last;
    logic             d, bo;
    logic [WIDTH-1:0] diff_n;

    sub_bit_cell u_cell (
        .x  (sa[0]),
        .y  (sb[0]),
        .bi (brw),
        .d  (d),
        .bo (bo)
    );

    assign diff_n = {d, diff_r[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.res_ack) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (load) begin
            sa     <= bus.a;
            sb     <= bus.b;
            brw    <= bus.bin;
            cnt    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (step) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            brw    <= bo;
            diff_r <= diff_n;
            if (last) begin
                // brw here is still the borrow into the MSB, so the
                // overflow flag is captured directly instead of storing it.
                bout_r <= bo;
                ovf_r  <= brw ^ bo;
                zero_r <= (diff_n == '0);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: self-checking bench for serial_sub at WIDTH=8 and WIDTH=16.
module tb_serial_sub;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    serial_sub_if #(.WIDTH(8))  i8 ();
    serial_sub_if #(.WIDTH(16)) i16 ();

    serial_sub #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_sub #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        i8.a = a; i8.b = b; i8.bin = bi; i8.start = 1'b1;
        @(posedge clk); #1;
        i8.start = 1'b0;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic bi);
        i16.a = a; i16.b = b; i16.bin = bi; i16.start = 1'b1;
        @(posedge clk); #1;
        i16.start = 1'b0;
    endtask

    // Cycles after the accepting edge until res_valid; bounded.
    task automatic wait_valid8(output int lat);
        lat = 0;
        while (!i8.res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_valid16(output int lat);
        lat = 0;
        while (!i16.res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack8();
        i8.res_ack = 1'b1;
        @(posedge clk); #1;
        i8.res_ack = 1'b0;
    endtask

    task automatic ack16();
        i16.res_ack = 1'b1;
        @(posedge clk); #1;
        i16.res_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({i8.busy, i8.res_valid, i8.diff, i8.bout, i8.ovf, i8.zero} !== 12'h0) begin
            $display("FAIL reset8: got busy=%b vld=%b diff=%h bout=%b ovf=%b zero=%b, want all 0",
                     i8.busy, i8.res_valid, i8.diff, i8.bout, i8.ovf, i8.zero);
        end else pass_cnt++;
        total_cnt++;
        if ({i16.busy, i16.res_valid, i16.diff, i16.bout, i16.ovf, i16.zero} !== 20'h0) begin
            $display("FAIL reset16: got busy=%b vld=%b diff=%h bout=%b ovf=%b zero=%b, want all 0",
                     i16.busy, i16.res_valid, i16.diff, i16.bout, i16.ovf, i16.zero);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0]  ta [4] = '{8'h00, 8'h80, 8'h05, 8'hFF};
        logic [7:0]  tb [4] = '{8'h01, 8'h01, 8'h05, 8'h00};
        logic        tbi[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [10:0] exp[4] = '{{8'hFF, 3'b100}, {8'h7F, 3'b010},
                                {8'h00, 3'b001}, {8'hFE, 3'b000}};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start8(ta[i], tb[i], tbi[i]);
            total_cnt++;
            if (i8.busy !== 1'b1) begin
                $display("FAIL dir_busy[%0d]: got %b want 1", i, i8.busy);
            end else pass_cnt++;
            wait_valid8(lat);
            total_cnt++;
            if (lat != 8) begin
                $display("FAIL dir_latency[%0d]: got %0d want 8", i, lat);
            end else pass_cnt++;
            total_cnt++;
            if ({i8.diff, i8.bout, i8.ovf, i8.zero} !== exp[i]) begin
                $display("FAIL dir_result[%0d]: got diff=%h bout=%b ovf=%b zero=%b want %h/%b",
                         i, i8.diff, i8.bout, i8.ovf, i8.zero, exp[i][10:3], exp[i][2:0]);
            end else pass_cnt++;
            ack8();
            total_cnt++;
            if ({i8.busy, i8.res_valid, i8.diff, i8.bout, i8.ovf, i8.zero} !== {2'b00, exp[i]}) begin
                $display("FAIL dir_after_ack[%0d]: got busy=%b vld=%b diff=%h flags=%b%b%b",
                         i, i8.busy, i8.res_valid, i8.diff, i8.bout, i8.ovf, i8.zero);
            end else pass_cnt++;
        end
    endtask

    task automatic test_hold_ack();
        int lat;
        start8(8'h3C, 8'h15, 1'b0);
        wait_valid8(lat);
        for (int i = 0; i < 5; i++) begin
            i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom);
            i8.start = 1'b1;
            @(posedge clk); #1;
            total_cnt++;
            if ({i8.res_valid, i8.diff, i8.bout, i8.ovf, i8.zero} !== {1'b1, 8'h27, 3'b000}) begin
                $display("FAIL hold[%0d]: got vld=%b diff=%h flags=%b%b%b want 1/27/000",
                         i, i8.res_valid, i8.diff, i8.bout, i8.ovf, i8.zero);
            end else pass_cnt++;
        end
        i8.res_ack = 1'b1;
        @(posedge clk); #1;
        i8.res_ack = 1'b0;
        i8.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({i8.busy, i8.res_valid, i8.diff} !== {2'b00, 8'h27}) begin
                $display("FAIL ack_with_start[%0d]: got busy=%b vld=%b diff=%h want 0/0/27",
                         i, i8.busy, i8.res_valid, i8.diff);
            end else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start8(8'h10, 8'h20, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({i8.busy, i8.res_valid, i8.diff, i8.bout, i8.ovf, i8.zero} !== 12'h0) begin
            $display("FAIL mid_reset: got busy=%b vld=%b diff=%h flags=%b%b%b want all 0",
                     i8.busy, i8.res_valid, i8.diff, i8.bout, i8.ovf, i8.zero);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start8(8'h10, 8'h20, 1'b0);
        wait_valid8(lat);
        total_cnt++;
        if (lat != 8) begin
            $display("FAIL post_reset_latency: got %0d want 8", lat);
        end else pass_cnt++;
        total_cnt++;
        if ({i8.diff, i8.bout, i8.ovf, i8.zero} !== {8'hF0, 3'b100}) begin
            $display("FAIL post_reset_result: got diff=%h flags=%b%b%b want F0/100",
                     i8.diff, i8.bout, i8.ovf, i8.zero);
        end else pass_cnt++;
        ack8();
    endtask

    task automatic test_random8();
        logic [7:0] a, b, ed;
        logic       bi, eb, eo, ez;
        int         s, u, lat;
        for (int n = 0; n < 1000; n++) begin
            a  = (n % 8 == 0) ? 8'h80 : 8'($urandom);
            b  = (n % 11 == 0) ? 8'h7F : 8'($urandom);
            bi = 1'($urandom);
            u  = int'(a) - int'(b) - int'(bi);
            s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
            ed = 8'(u);
            eb = (u < 0);
            eo = (s < -128) || (s > 127);
            ez = (ed == 8'h00);
            start8(a, b, bi);
            wait_valid8(lat);
            total_cnt++;
            if (lat != 8) begin
                $display("FAIL rnd8_latency[%0d]: got %0d want 8", n, lat);
            end else pass_cnt++;
            total_cnt++;
            if ({i8.diff, i8.bout, i8.ovf, i8.zero} !== {ed, eb, eo, ez}) begin
                $display("FAIL rnd8_result[%0d]: %h-%h-%b got %h/%b%b%b want %h/%b%b%b",
                         n, a, b, bi, i8.diff, i8.bout, i8.ovf, i8.zero, ed, eb, eo, ez);
            end else pass_cnt++;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 ack8();
        end
    endtask

    task automatic test_random16();
        logic [15:0] a, b, ed;
        logic        bi, eb, eo, ez;
        int          s, u, lat;
        for (int n = 0; n < 1000; n++) begin
            a  = (n % 9 == 0) ? 16'h0000 : 16'($urandom);
            b  = (n % 7 == 0) ? 16'hFFFF : 16'($urandom);
            bi = 1'($urandom);
            u  = int'(a) - int'(b) - int'(bi);
            s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
            ed = 16'(u);
            eb = (u < 0);
            eo = (s < -32768) || (s > 32767);
            ez = (ed == 16'h0000);
            start16(a, b, bi);
            wait_valid16(lat);
            total_cnt++;
            if (lat != 16) begin
                $display("FAIL rnd16_latency[%0d]: got %0d want 16", n, lat);
            end else pass_cnt++;
            total_cnt++;
            if ({i16.diff, i16.bout, i16.ovf, i16.zero} !== {ed, eb, eo, ez}) begin
                $display("FAIL rnd16_result[%0d]: %h-%h-%b got %h/%b%b%b want %h/%b%b%b",
                         n, a, b, bi, i16.diff, i16.bout, i16.ovf, i16.zero, ed, eb, eo, ez);
            end else pass_cnt++;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 ack16();
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b1;
        i8.start  = 1'b0; i8.a  = '0; i8.b  = '0; i8.bin  = 1'b0; i8.res_ack  = 1'b0;
        i16.start = 1'b0; i16.a = '0; i16.b = '0; i16.bin = 1'b0; i16.res_ack = 1'b0;
        test_reset();
        test_directed();
        test_hold_ack();
        test_reset_mid_run();
        test_random8();
        test_random16();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
